// File: rtl/cmp_share_arb.sv
// cmp_share_arb: round-robin arbiter sharing one registered n-bit comparator among NREQ requesters
// Optional signed compare (sgn input) when CMP_SHARE_ARB_SIGNED_EN is defined.
module cmp_share_arb #(
  parameter int n    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*n-1:0] a_in,
  input  logic [NREQ*n-1:0] b_in,
`ifdef CMP_SHARE_ARB_SIGNED_EN
  input  logic              sgn,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_agtb,
  output logic              rsp_aeqb,
  output logic              rsp_altb,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;
  localparam logic [IDW:0] NR = (IDW+1)'(NREQ);
  state_t state_q;
  logic [IDW-1:0] rr_q, id_q, rsp_id_q, win_d, idx_d;
  logic [IDW:0] sum_d;
  logic found_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [n-1:0] a_q, b_q, ax_d, bx_d;
  logic sgn_q, sgn_w, valid_q;
  logic [2:0] flags_q;
  logic [NREQ-1:0][n-1:0] a_pk, b_pk;
  assign a_pk = a_in;
  assign b_pk = b_in;
`ifdef CMP_SHARE_ARB_SIGNED_EN
  assign sgn_w = sgn;
`else
  assign sgn_w = 1'b0;
`endif
  // first set request at or above rr_q, wrapping modulo NREQ
  always_comb begin
    win_d = '0;
    found_d = 1'b0;
    gnt_d = '0;
    sum_d = '0;
    idx_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum_d = {1'b0, rr_q} + (IDW+1)'(k);
      sum_d = (sum_d >= NR) ? sum_d - NR : sum_d;
      idx_d = sum_d[IDW-1:0];
      if (!found_d && req[idx_d]) begin
        found_d = 1'b1;
        win_d = idx_d;
        gnt_d[idx_d] = 1'b1;
      end
    end
  end
  // flipping the sign bit turns a two's-complement compare into an unsigned one
  assign ax_d = {a_q[n-1] ^ sgn_q, a_q[n-2:0]};
  assign bx_d = {b_q[n-1] ^ sgn_q, b_q[n-2:0]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      rsp_id_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q <= found_d ? gnt_d : '0;
          state_q <= found_d ? CMP : IDLE;
          if (found_d) begin
            a_q   <= a_pk[win_d];
            b_q   <= b_pk[win_d];
            sgn_q <= sgn_w;
            id_q  <= win_d;
          end
        end
        CMP: begin
          gnt_q    <= '0;
          flags_q  <= {ax_d > bx_d, ax_d == bx_d, ax_d < bx_d};
          rsp_id_q <= id_q;
          valid_q  <= 1'b1;
          rr_q     <= (id_q == IDW'(NREQ-1)) ? '0 : id_q + 1'b1;
          state_q  <= RSP;
        end
        RSP: begin
          valid_q <= rsp_ready ? 1'b0 : 1'b1;
          state_q <= rsp_ready ? IDLE : RSP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign gnt       = gnt_q;
  assign rsp_valid = valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_agtb  = flags_q[2];
  assign rsp_aeqb  = flags_q[1];
  assign rsp_altb  = flags_q[0];
  assign busy      = state_q != IDLE;
endmodule
